// File: rtl/versat_databus_arbiter.sv
// rtl/versat_databus_arbiter.sv - round-robin arbiter sharing one native memory port among N Versat I/O units
// One transfer in flight at a time; the search starts one slot past the last grant so nobody waits more than N-1 transfers.
module versat_databus_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_MASTERS-1:0]                m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]         m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]         m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0]     m_wstrb,
  output logic [N_MASTERS-1:0]                m_ready,
  output logic [DATA_W-1:0]                   m_rdata,
  output logic                                s_valid,
  output logic [ADDR_W-1:0]                   s_addr,
  output logic [DATA_W-1:0]                   s_wdata,
  output logic [(DATA_W/8)-1:0]               s_wstrb,
  input  logic                                s_ready,
  input  logic [DATA_W-1:0]                   s_rdata,
  output logic                                busy,
  output logic [$clog2(N_MASTERS)-1:0]        grant_id
);

  localparam int ID_W   = $clog2(N_MASTERS);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_grant;
  logic [ID_W-1:0] r_last;
  logic [ID_W-1:0] w_sel;
  logic            w_any_req;
  logic            w_load_grant;
  logic            w_load_last;
  logic            w_req_held;

  // Scan upward from last+1 with wrap; the first active request wins.
  always_comb begin : rr_select
    int idx;
    w_sel     = '0;
    w_any_req = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = (int'(r_last) + 1 + k) % N_MASTERS;
      if (!w_any_req && m_valid[idx]) begin
        w_any_req = 1'b1;
        w_sel     = ID_W'(idx);
      end
    end
  end

  assign w_req_held = m_valid[r_grant];
  assign s_addr     = m_addr[int'(r_grant)*ADDR_W +: ADDR_W];
  assign s_wdata    = m_wdata[int'(r_grant)*DATA_W +: DATA_W];
  assign s_wstrb    = m_wstrb[int'(r_grant)*STRB_W +: STRB_W];
  assign m_rdata    = s_rdata;
  assign busy       = (r_state == S_GRANT);
  assign grant_id   = r_grant;

  always_comb begin : fsm_next
    w_state_nxt  = r_state;
    w_load_grant = 1'b0;
    w_load_last  = 1'b0;
    s_valid      = 1'b0;
    m_ready      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt  = S_GRANT;
          w_load_grant = 1'b1;
        end
      end
      S_GRANT: begin
        s_valid          = w_req_held;
        m_ready[r_grant] = w_req_held & s_ready;
        // A dropped request abandons the slot exactly like a completion, minus the m_ready.
        if (!w_req_held || s_ready) begin
          w_state_nxt = S_IDLE;
          w_load_last = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= ID_W'(N_MASTERS - 1);
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_grant) r_grant <= w_sel;
      if (w_load_last)  r_last  <= r_grant;
    end
  end

endmodule

// File: tb/tb_versat_databus_arbiter.sv
// tb/tb_versat_databus_arbiter.sv - self-checking bench for versat_databus_arbiter
// Directed scenarios followed by a randomized run against a transaction-level round-robin model.
module tb_versat_databus_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N-1:0]    m_ready;
  logic [DW-1:0]   m_rdata;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_ready;
  logic [DW-1:0]   s_rdata;
  logic            busy;
  logic [1:0]      grant_id;

  logic [AW-1:0]   a_q [N];
  logic [DW-1:0]   d_q [N];
  logic [SW-1:0]   s_q [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  versat_databus_arbiter #(.N_MASTERS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = a_q[i];
      m_wdata[i*DW +: DW] = d_q[i];
      m_wstrb[i*SW +: SW] = s_q[i];
    end
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    a_q[i] = a;
    d_q[i] = d;
    s_q[i] = s;
    pack();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; m_valid = '0; s_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Round-robin rule: first requester at or after (last+1) mod N.
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; m_valid = '0; s_ready = 1'b0; s_rdata = '0;
    for (int i = 0; i < N; i++) set_slot(i, '0, '0, '0);
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL reset_s_valid: got %0b want 0", s_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (m_ready !== 4'b0) begin n_bad++; $display("FAIL reset_m_ready: got %b want 0000", m_ready); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    set_slot(2, 32'h100, 32'h0, 4'h0); m_valid = 4'b0100; s_ready = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: busy got %0b want 0", busy); end
    @(negedge clk); #1;
    n_cmp++; if ({s_valid, grant_id} !== 3'b1_10) begin n_bad++; $display("FAIL single_grant: s_valid/grant got %0b/%0d want 1/2", s_valid, grant_id); end
    n_cmp++; if (s_addr !== 32'h100) begin n_bad++; $display("FAIL single_addr: got %h want 00000100", s_addr); end
    n_cmp++; if (m_ready !== 4'b0) begin n_bad++; $display("FAIL single_early_ready: got %b want 0000", m_ready); end
    @(negedge clk);
    s_ready = 1'b1; s_rdata = 32'hDEADBEEF; #1;
    n_cmp++; if (m_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", m_ready); end
    n_cmp++; if (m_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_rdata: got %h want deadbeef", m_rdata); end
    @(negedge clk);
    m_valid = '0; s_ready = 1'b0; #1;
    n_cmp++; if ({busy, m_ready} !== 5'b0) begin n_bad++; $display("FAIL single_done: busy/m_ready got %0b/%b want 0/0000", busy, m_ready); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp;
    reset_dut();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_slot(i, 32'h1000 + 4*i, 32'h0, 4'h0);
    m_valid = '1; s_ready = 1'b1; #1;
    n_cmp++; if (m_ready !== 4'b0) begin n_bad++; $display("FAIL fair_first_idle: got %b want 0000", m_ready); end
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk); #1;
      exp = (c % 2 == 1) ? N'(1 << (((c - 1) / 2) % N)) : '0;
      n_cmp++; if (m_ready !== exp) begin n_bad++; $display("FAIL fair_cycle%0d: m_ready got %b want %b", c, m_ready, exp); end
    end
    @(negedge clk);
    m_valid = '0; s_ready = 1'b0;
  endtask

  task automatic test_wrap_skip();
    logic [N-1:0] add_t [5] = '{4'b1010, 4'b0000, 4'b0100, 4'b0011, 4'b0000};
    int           win_t [5] = '{1, 3, 2, 0, 1};
    int           prev = -1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (prev >= 0) m_valid[prev] = 1'b0;
      m_valid = m_valid | add_t[k]; s_ready = 1'b1; #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wrap_idle%0d: busy got %0b want 0", k, busy); end
      @(negedge clk); #1;
      n_cmp++; if (m_ready !== N'(1 << win_t[k]) || grant_id !== 2'(win_t[k]))
        begin n_bad++; $display("FAIL wrap_step%0d: m_ready/grant got %b/%0d want %b/%0d", k, m_ready, grant_id, N'(1 << win_t[k]), win_t[k]); end
      prev = win_t[k];
    end
    @(negedge clk);
    m_valid[prev] = 1'b0; s_ready = 1'b0;
  endtask

  task automatic test_stall();
    @(negedge clk);
    set_slot(0, 32'h400, 32'hA5A5A5A5, 4'hF); m_valid = 4'b0001; s_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 6) s_ready = 1'b1;
      #1;
      n_cmp++; if ({s_valid, s_addr, s_wdata, s_wstrb} !== {1'b1, 32'h400, 32'hA5A5A5A5, 4'hF})
        begin n_bad++; $display("FAIL stall_hold%0d: got %0b/%h/%h/%h want 1/00000400/a5a5a5a5/f", c, s_valid, s_addr, s_wdata, s_wstrb); end
      n_cmp++; if (m_ready !== ((c == 6) ? 4'b0001 : 4'b0000))
        begin n_bad++; $display("FAIL stall_ready%0d: got %b want %b", c, m_ready, (c == 6) ? 4'b0001 : 4'b0000); end
    end
    @(negedge clk);
    m_valid = '0; s_ready = 1'b0; #1;
    n_cmp++; if ({s_valid, m_ready} !== 5'b0) begin n_bad++; $display("FAIL stall_release: s_valid/m_ready got %0b/%b want 0/0000", s_valid, m_ready); end
  endtask

  task automatic test_abort();
    @(negedge clk);
    set_slot(1, 32'h180, 32'h0, 4'h0); m_valid = 4'b0010; s_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if ({s_valid, grant_id} !== 3'b1_01) begin n_bad++; $display("FAIL abort_grant: s_valid/grant got %0b/%0d want 1/1", s_valid, grant_id); end
    @(negedge clk);
    set_slot(2, 32'h200, 32'h0, 4'h0); m_valid[2] = 1'b1; #1;
    n_cmp++; if ({s_valid, grant_id} !== 3'b1_01) begin n_bad++; $display("FAIL abort_no_steal: s_valid/grant got %0b/%0d want 1/1", s_valid, grant_id); end
    @(negedge clk);
    m_valid[1] = 1'b0; s_ready = 1'b1; #1;
    n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL abort_s_valid: got %0b want 0", s_valid); end
    n_cmp++; if (m_ready !== 4'b0) begin n_bad++; $display("FAIL abort_m_ready: got %b want 0000", m_ready); end
    @(negedge clk);
    s_ready = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: busy got %0b want 0", busy); end
    @(negedge clk);
    s_ready = 1'b1; #1;
    n_cmp++; if (m_ready !== 4'b0100 || s_addr !== 32'h200)
      begin n_bad++; $display("FAIL abort_next: m_ready/addr got %b/%h want 0100/00000200", m_ready, s_addr); end
    @(negedge clk);
    m_valid = '0; s_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_slot(3, 32'h300, 32'h12345678, 4'h3); m_valid = 4'b1000; s_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if ({busy, s_valid, grant_id} !== 4'b11_11) begin n_bad++; $display("FAIL rstmid_grant: busy/s_valid/grant got %0b/%0b/%0d want 1/1/3", busy, s_valid, grant_id); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({busy, s_valid, grant_id} !== 4'b0) begin n_bad++; $display("FAIL rstmid_async: busy/s_valid/grant got %0b/%0b/%0d want 0/0/0", busy, s_valid, grant_id); end
    m_valid = '0;
    @(negedge clk);
    rst = 1'b0; m_valid = '1; s_ready = 1'b1; #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: busy got %0b want 0", busy); end
    @(negedge clk); #1;
    n_cmp++; if (m_ready !== 4'b0001) begin n_bad++; $display("FAIL rstmid_priority: m_ready got %b want 0001", m_ready); end
    @(negedge clk);
    m_valid = '0; s_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] prev_req = '0;
    logic [N-1:0] exp_rdy;
    bit           prev_sv = 1'b0;
    bit           prev_done = 1'b0;
    bit           exp_sv;
    bit           drop [N];
    int           cur = 0;
    int           mdl_last = N - 1;
    int           ntx = 0;
    for (int i = 0; i < N; i++) drop[i] = 1'b0;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (drop[i]) begin
          m_valid[i] = 1'b0; drop[i] = 1'b0;
        end else if (!m_valid[i] && $urandom_range(2) == 0) begin
          a_q[i] = $urandom; d_q[i] = $urandom;
          s_q[i] = ($urandom_range(1) == 0) ? '0 : SW'($urandom);
          m_valid[i] = 1'b1;
        end
      end
      pack();
      s_ready = ($urandom_range(1) == 1); s_rdata = $urandom;
      #1;
      // A transfer is live if one was live and unfinished, or the previous idle cycle saw a request.
      exp_sv = prev_done ? 1'b0 : (prev_sv ? 1'b1 : (prev_req != '0));
      if (!prev_done && !prev_sv && prev_req != '0) cur = rr_pick(prev_req, mdl_last);
      n_cmp++; if (s_valid !== exp_sv) begin n_bad++; $display("FAIL rand_s_valid c%0d: got %0b want %0b", c, s_valid, exp_sv); end
      if (exp_sv) begin
        n_cmp++; if (grant_id !== 2'(cur)) begin n_bad++; $display("FAIL rand_grant c%0d: got %0d want %0d", c, grant_id, cur); end
        n_cmp++; if ({s_addr, s_wdata, s_wstrb} !== {a_q[cur], d_q[cur], s_q[cur]})
          begin n_bad++; $display("FAIL rand_mux c%0d: got %h/%h/%h want %h/%h/%h", c, s_addr, s_wdata, s_wstrb, a_q[cur], d_q[cur], s_q[cur]); end
      end
      exp_rdy = (exp_sv && s_ready) ? N'(1 << cur) : '0;
      n_cmp++; if (m_ready !== exp_rdy) begin n_bad++; $display("FAIL rand_m_ready c%0d: got %b want %b", c, m_ready, exp_rdy); end
      if (exp_sv && s_ready) begin
        n_cmp++; if (m_rdata !== s_rdata) begin n_bad++; $display("FAIL rand_rdata c%0d: got %h want %h", c, m_rdata, s_rdata); end
        mdl_last = cur; drop[cur] = 1'b1; ntx++;
      end
      prev_done = exp_sv && s_ready;
      prev_sv   = exp_sv;
      prev_req  = m_valid;
    end
    @(negedge clk);
    m_valid = '0; s_ready = 1'b0;
    n_cmp++; if (ntx < 40) begin n_bad++; $display("FAIL rand_throughput: transfers got %0d want >= 40", ntx); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_wrap_skip();
    test_stall();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/versat_databus_arbiter.md
# versat_databus_arbiter

Round-robin arbiter that shares one external native-interface memory port between N Versat I/O units (vread/vwrite style address generators). Each unit's databus port (valid/ready/addr/wdata/wstrb/rdata) connects to one requester slot. The single arbitrated port connects to the system memory or interconnect. One transfer is in flight at a time. Arbitration is fair: no requester waits more than N-1 transfers.

## Interface
- N_MASTERS, default 4: number of requester slots (2..16).
- DATA_W, default 32: data width.
- ADDR_W, default 32: address width (equals `IO_ADDR_W`).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- m_valid  in  N_MASTERS  request valid per master; held until its m_ready.
- m_addr  in  N_MASTERS*ADDR_W  packed addresses; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_wdata  in  N_MASTERS*DATA_W  packed write data.
- m_wstrb  in  N_MASTERS*DATA_W/8  packed byte strobes; all-zero means read.
- m_ready  out  N_MASTERS  transfer-complete pulse to the granted master only.
- m_rdata  out  DATA_W  read data, broadcast to all masters; valid when that master's m_ready is high.
- s_valid  out  1  request to memory.
- s_addr  out  ADDR_W  muxed address.
- s_wdata  out  DATA_W  muxed write data.
- s_wstrb  out  DATA_W/8  muxed strobes.
- s_ready  in  1  memory completion; s_rdata is valid in the same cycle.
- s_rdata  in  DATA_W  memory read data.
- busy  out  1  high while in GRANT state.
- grant_id  out  $clog2(N_MASTERS)  index of the current or most recent grant.

## Operation
- Two-state FSM: IDLE and GRANT.
- IDLE:
  - If any m_valid is set, select the first requester at or after pointer `ptr = (last + 1) mod N_MASTERS`, scanning upward with wrap.
  - Register the selection into grant_id and go to GRANT.
  - With no requests, stay in IDLE.
- GRANT:
  - s_valid = m_valid[grant_id]. s_addr, s_wdata and s_wstrb are muxed from slot grant_id.
  - m_ready[grant_id] = s_ready & s_valid. All other m_ready bits are 0.
  - m_rdata = s_rdata, passed through combinationally.
  - On s_ready & s_valid: set last <= grant_id and go to IDLE.
  - If m_valid[grant_id] drops before completion (protocol violation): s_valid falls the same cycle. The arbiter goes to IDLE with last <= grant_id and issues no m_ready.
- When not in GRANT: s_valid = 0, m_ready = 0. s_addr, s_wdata and s_wstrb hold the slot grant_id values, so they stay stable but are don't-care.
- Only one s_valid/s_ready transfer can be outstanding. A master never sees m_ready without having m_valid high.
- Master requests change only at reset or after their own m_ready; grant changes never occur mid-transfer.

## Timing
- Reset (asynchronous) forces the following immediately:
  - state = IDLE, last = N_MASTERS-1 (so master 0 has first priority), grant_id = 0.
  - s_valid = 0, m_ready = 0, busy = 0.
- Arbitration latency is 1 cycle: m_valid rises in cycle t (state IDLE), then grant is registered and s_valid = 1 in cycle t+1.
- Best case: s_ready in cycle t+1 gives m_ready in t+1, IDLE in t+2, and the next grant in t+3. Peak throughput is 1 transfer per 2 cycles.
- Slave stall: s_valid, s_addr, s_wdata and s_wstrb stay stable while s_ready is low, for any number of cycles.
- Simultaneous requests in the same cycle resolve by round-robin from ptr. The lowest index wins only when ptr = 0.
- Wrap-around: with last = N_MASTERS-1, ptr = 0. With last = 2 and requests on {0, 1}, master 0 wins.
- A new m_valid arriving during GRANT is considered at the next IDLE cycle.
- Reset mid-transfer: s_valid drops asynchronously and the memory transaction is abandoned. Masters must also be reset.
- m_ready, s_valid and m_rdata are combinational from the registered state and inputs. There are no combinational paths from s_ready to s_valid.

## Test plan
- Single read:
  - Stimulus: master 2 asserts m_valid with addr 0x100 and wstrb 0. Memory returns 0xDEADBEEF with s_ready 1 cycle after s_valid.
  - Response: s_addr = 0x100 and grant_id = 2. m_ready[2] pulses for exactly 1 cycle with m_rdata = 0xDEADBEEF. All other m_ready stay 0.
- Fairness:
  - Stimulus: all 4 masters request continuously; memory has 0 stall.
  - Response: grant order is 0, 1, 2, 3, 0, 1… and each m_ready is spaced 2 cycles apart.
- Wrap and skip:
  - Stimulus: after master 3 is served, masters 1 and 3 request.
  - Response: 1 is granted first, then 3.
- Slave stall:
  - Stimulus: master 0 writes wdata 0xA5A5A5A5 with wstrb 0xF; s_ready is held low for 5 cycles.
  - Response: s_* outputs are stable for 6 cycles, with a single m_ready[0] in the cycle s_ready rises.
- Abort:
  - Stimulus: the granted master drops m_valid while the memory is stalled.
  - Response: s_valid falls the same cycle, no m_ready is issued, FSM returns to IDLE, and the next requester is served normally.
- Reset mid-transfer:
  - Stimulus: assert rst while in GRANT.
  - Response: s_valid = 0, busy = 0 and grant_id = 0 immediately. After release, master 0 has top priority.
